// File: rtl/spi_adc_arbiter.sv
// spi_adc_arbiter
// Round-robin arbiter that shares one SPI ADC front-end among NUM_REQ
// requesters. A granted request selects its analog mux channel, waits for the
// mux to settle, pulses adcStart, then returns the captured sample (or a
// timeout error) to the owning requester as a one-cycle response strobe.
// Only one conversion is in flight at a time.

module spi_adc_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int CH_BITS        = 3,
  parameter int DATA_BITS      = 12,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           reqValid,
  input  logic [NUM_REQ*CH_BITS-1:0]   reqChannel,
  output logic [NUM_REQ-1:0]           reqReady,
  output logic [NUM_REQ-1:0]           rspValid,
  output logic [DATA_BITS-1:0]         rspData,
  output logic                         rspError,
  output logic [CH_BITS-1:0]           adcChannel,
  output logic                         adcStart,
  input  logic                         adcDataValid,
  input  logic [DATA_BITS-1:0]         adcData
);

  // Owner index width; a single requester still needs a 1-bit index.
  localparam int OWN_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // One shared counter serves both the settle delay and the WAIT timeout,
  // so it is sized for the larger of the two and can never wrap.
  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES
                                                            : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST  =
    CNT_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [OWN_W-1:0] LAST_REQ   = OWN_W'(NUM_REQ - 1);
  localparam logic [OWN_W:0]   NUM_REQ_W  = (OWN_W + 1)'(NUM_REQ);

  // Sequencer states.
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETTLE  = 3'd1;
  localparam logic [2:0] START   = 3'd2;
  localparam logic [2:0] WAIT    = 3'd3;
  localparam logic [2:0] RESPOND = 3'd4;

  logic [2:0]           state_q,     state_d;
  logic [OWN_W-1:0]     ptr_q,       ptr_d;
  logic [OWN_W-1:0]     owner_q,     owner_d;
  logic [CH_BITS-1:0]   chan_q,      chan_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [DATA_BITS-1:0] rsp_data_q,  rsp_data_d;
  logic                 rsp_error_q, rsp_error_d;

  logic                 grant_found;
  logic [OWN_W-1:0]     grant_idx;
  logic [OWN_W:0]       grant_sum;
  logic [OWN_W-1:0]     grant_cand;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   rsp_valid;

  // Round-robin search: first valid requester at or after ptr, with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_sum   = '0;
    grant_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      grant_sum = {1'b0, ptr_q} + (OWN_W + 1)'(k);
      if (grant_sum >= NUM_REQ_W) begin
        grant_sum = grant_sum - NUM_REQ_W;
      end
      grant_cand = grant_sum[OWN_W-1:0];
      if (!grant_found && reqValid[grant_cand]) begin
        grant_found = 1'b1;
        grant_idx   = grant_cand;
      end
    end
  end

  // One-hot accept, offered only while the sequencer is idle.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // One-hot response strobe to the owner of the finished conversion.
  always_comb begin
    rsp_valid = '0;
    if (state_q == RESPOND) begin
      rsp_valid[owner_q] = 1'b1;
    end
  end

  // Sequencer next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    chan_d      = chan_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          // The channel slice is sampled only here, at the accept edge.
          owner_d = grant_idx;
          chan_d  = reqChannel[grant_idx*CH_BITS +: CH_BITS];
          ptr_d   = (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
          cnt_d   = '0;
          state_d = (SETTLE_CYCLES == 0) ? START : SETTLE;
        end
      end

      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      START: begin
        // adcStart is high for this single cycle; timeout count starts fresh.
        cnt_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        // A sample arriving on the last WAIT cycle beats the timeout.
        if (adcDataValid) begin
          rsp_data_d  = adcData;
          rsp_error_d = 1'b0;
          state_d     = RESPOND;
        end else if (cnt_q == TIMEOUT_LAST) begin
          rsp_data_d  = '0;
          rsp_error_d = 1'b1;
          state_d     = RESPOND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESPOND: begin
        // Response fields read as zero whenever no strobe is active.
        rsp_data_d  = '0;
        rsp_error_d = 1'b0;
        state_d     = IDLE;
      end

      default: begin
        state_d     = IDLE;
        rsp_data_d  = '0;
        rsp_error_d = 1'b0;
      end
    endcase
  end

  // State registers; reset drops any in-flight conversion without response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      chan_q      <= '0;
      cnt_q       <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      chan_q      <= chan_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign reqReady   = req_ready;
  assign rspValid   = rsp_valid;
  assign rspData    = rsp_data_q;
  assign rspError   = rsp_error_q;
  assign adcChannel = chan_q;
  assign adcStart   = (state_q == START);

endmodule

// File: doc/spi_adc_arbiter.md
Name: spi_adc_arbiter

Overview:
- Shares one SPI ADC front-end (chip-enable/sample/transfer sequencer plus shift path) among NUM_REQ requesters.
- Each requester asks for one conversion on a channel of the external analog mux.
- Arbiter grants round-robin, drives the mux select, waits a settle time, pulses a start, collects the sample and returns it to the winning requester.
- Sits between the per-channel sample consumers (filters, beamformer taps) and the SPI ADC core.

Parameters:
- NUM_REQ, 4, number of requesters
- CH_BITS, 3, width of analog mux channel select
- DATA_BITS, 12, ADC sample width
- SETTLE_CYCLES, 4, clk cycles mux is held before adcStart; 0 allowed
- TIMEOUT_CYCLES, 64, max clk cycles in WAIT before error response; >= 1

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- reqValid  in  NUM_REQ  per-requester conversion request
- reqChannel  in  NUM_REQ*CH_BITS  channel per requester; slice i = [i*CH_BITS +: CH_BITS]
- reqReady  out  NUM_REQ  one-hot accept; transfer occurs when reqValid[i] & reqReady[i]
- rspValid  out  NUM_REQ  one-hot one-cycle response strobe to owning requester
- rspData  out  DATA_BITS  sample, valid while any rspValid
- rspError  out  1  1 = timeout, valid while any rspValid
- adcChannel  out  CH_BITS  analog mux select
- adcStart  out  1  one-cycle start pulse to SPI ADC core
- adcDataValid  in  1  SPI core sample-complete strobe
- adcData  in  DATA_BITS  SPI core sample, valid with adcDataValid

Behaviour:
- Reset values: state IDLE, reqReady 0, rspValid 0, rspData 0, rspError 0, adcChannel 0, adcStart 0, RR pointer 0, counters 0.
- States: IDLE, SETTLE, START, WAIT, RESPOND.
- IDLE:
  - reqReady combinational, one-hot: the first i with reqValid[i], searching from ptr upward with wrap.
  - All zeros when no reqValid, or when state is not IDLE.
  - On accept (cycle T): latch owner index and reqChannel slice; ptr <= (owner+1) mod NUM_REQ.
  - Next state is SETTLE, or START if SETTLE_CYCLES==0.
- SETTLE: adcChannel = latched channel (registered, updated at accept edge). Stays exactly SETTLE_CYCLES cycles (T+1..T+SETTLE_CYCLES), then START.
- START: adcStart=1 for exactly one cycle (cycle T+SETTLE_CYCLES+1), then WAIT. adcChannel held.
- WAIT:
  - Timeout counter cleared on entry, +1 per cycle.
  - On adcDataValid: capture adcData, rspError=0, go RESPOND.
  - If counter reaches TIMEOUT_CYCLES-1 without adcDataValid: rspData=0, rspError=1, go RESPOND.
  - adcDataValid in the same cycle as the timeout: data wins, no error.
- RESPOND: rspValid[owner]=1 for exactly one cycle with rspData/rspError stable, then IDLE. No backpressure on responses.
- Latency:
  - Accept at T -> adcStart at T+SETTLE_CYCLES+1.
  - adcDataValid at W -> rspValid at W+1.
  - Earliest next accept at W+2.
- adcDataValid outside WAIT: ignored; no response, no state change.
- adcChannel holds its last value in IDLE; it changes only at accept.
- Requester deasserting reqValid without a handshake: legal, nothing latched. Channel slice is sampled only at the accept edge.
- At most one outstanding conversion. Requesters not granted keep reqValid high; fairness guarantees service within NUM_REQ grants.
- rsp* outputs return to 0 the cycle after RESPOND (rspData holds 0 when not valid).
- Reset mid-operation (any state) returns all outputs and ptr to reset values immediately. The in-flight request is dropped with no response.
- Counters sized $clog2(max(SETTLE_CYCLES,TIMEOUT_CYCLES)+1) bits; no wrap possible.

Test Plan:
- Single request: reqValid=4'b0010, ch1=5, SETTLE 4; model returns 12'hABC 20 cycles after adcStart -> reqReady[1] at T, adcChannel=5 from T+1, adcStart at T+5, rspValid=4'b0010 with rspData=12'hABC, rspError=0.
- Round-robin: reqValid=4'b1111 held, channels 0..3, model always responds -> grant order 0,1,2,3,0; each rspValid goes to the matching owner with that channel's sample.
- Timeout: TIMEOUT 64, model never asserts adcDataValid -> rspValid to owner exactly 64 cycles after entering WAIT, rspData=0, rspError=1; next request is served normally.
- Data/timeout collision: adcDataValid on the final WAIT cycle with 12'h123 -> rspData=12'h123, rspError=0.
- Spurious/reset: adcDataValid pulse in IDLE -> no rspValid. Assert rst during SETTLE -> all outputs 0 and ptr 0; after release, reqValid=4'b1000 is granted to requester 3.
- SETTLE_CYCLES=0 build: accept at T -> adcStart at T+1.
